// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), optional 7-segment output via BIN2BCD_SEG7_EN.
// Latency BIN_W+2 cycles start-to-done; start is ignored while busy or in the DONE cycle (no backpressure).
// Results hold until the next done pulse; reset_n aborts any conversion without a done pulse.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef BIN2BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIN_W-1:0]   bin_work;
    logic [BCD_W-1:0]   bcd_work;
    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_sticky;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Add-3 correction on every digit before the shift, all digits in parallel.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef BIN2BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_nxt;
    logic                lead_seen;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // Scan from the top digit: blank until the first nonzero digit, digit 0 always shown.
    always_comb begin
        seg_nxt   = '1;
        lead_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((bcd_work[4*i +: 4] != 4'd0) || (i == 0)) begin
                lead_seen = 1'b1;
            end
            if (ovf_sticky) begin
                seg_nxt[7*i +: 7] = 7'b0111111;
            end else if (lead_seen) begin
                seg_nxt[7*i +: 7] = seg_of(bcd_work[4*i +: 4]);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bin_work   <= '0;
            bcd_work   <= '0;
            ovf_sticky <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
`ifdef BIN2BCD_SEG7_EN
            seg        <= '1;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_work   <= bin;
                        bcd_work   <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= '0;
                    end
                end
                SHIFT: begin
                    bcd_work   <= {bcd_adj[BCD_W-2:0], bin_work[BIN_W-1]};
                    bin_work   <= {bin_work[BIN_W-2:0], 1'b0};
                    ovf_sticky <= ovf_sticky | bcd_adj[BCD_W-1];
                    cnt        <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd      <= bcd_work;
                    overflow <= ovf_sticky;
                    done     <= 1'b1;
`ifdef BIN2BCD_SEG7_EN
                    seg      <= seg_nxt;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 3-digit and a 2-digit instance on a shared clock and reset.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start3 = 1'b0;
    logic [7:0]  bin3 = 8'd0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        start2 = 1'b0;
    logic [7:0]  bin2 = 8'd0;
    logic        busy2, done2, ovf2;
    logic [7:0]  bcd2;
`ifdef BIN2BCD_SEG7_EN
    logic [20:0] seg3;
    logic [13:0] seg2;
`endif

    int tests = 0;
    int fails = 0;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .bin(bin3),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
`ifdef BIN2BCD_SEG7_EN
        , .seg(seg3)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
`ifdef BIN2BCD_SEG7_EN
        , .seg(seg2)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a one-cycle start from the current (idle) cycle = cycle 0 and waits for done.
    task automatic run_conv(input int which, input logic [7:0] b,
                            output logic [11:0] r, output logic ovf,
                            output int lat, output int busy_cyc);
        bit seen;
        seen = 0; lat = -1; busy_cyc = 0; r = '0; ovf = 1'b0;
        if (which == 3) begin start3 = 1'b1; bin3 = b; end
        else begin start2 = 1'b1; bin2 = b; end
        tick();
        start3 = 1'b0;
        start2 = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if ((which == 3) ? busy3 : busy2) busy_cyc++;
            if ((which == 3) ? done3 : done2) begin
                seen = 1;
                lat  = c;
                r    = (which == 3) ? bcd3 : {4'h0, bcd2};
                ovf  = (which == 3) ? ovf3 : ovf2;
            end
            if (!seen) tick();
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL reset_busy3 got %b want 0", busy3); end
        tests++; if (done3 !== 1'b0) begin fails++; $display("FAIL reset_done3 got %b want 0", done3); end
        tests++; if (bcd3 !== 12'h000) begin fails++; $display("FAIL reset_bcd3 got %h want 000", bcd3); end
        tests++; if (ovf3 !== 1'b0) begin fails++; $display("FAIL reset_ovf3 got %b want 0", ovf3); end
        tests++; if (bcd2 !== 8'h00) begin fails++; $display("FAIL reset_bcd2 got %h want 00", bcd2); end
        tests++; if (done2 !== 1'b0) begin fails++; $display("FAIL reset_done2 got %b want 0", done2); end
`ifdef BIN2BCD_SEG7_EN
        tests++; if (seg3 !== 21'h1fffff) begin fails++; $display("FAIL reset_seg3 got %h want 1fffff", seg3); end
`endif
        tick(); tick();
        #2 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_max();
        logic [11:0] r; logic ovf; int lat, bc, extra;
        run_conv(3, 8'd255, r, ovf, lat, bc);
        tests++; if (r !== 12'h255) begin fails++; $display("FAIL max_bcd got %h want 255", r); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL max_ovf got %b want 0", ovf); end
        tests++; if (lat != 10) begin fails++; $display("FAIL max_latency got %0d want 10", lat); end
        tests++; if (bc != 8) begin fails++; $display("FAIL max_busy_cycles got %0d want 8", bc); end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done3) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL max_single_done extra pulses %0d want 0", extra); end
        tests++; if (bcd3 !== 12'h255) begin fails++; $display("FAIL max_bcd_hold got %h want 255", bcd3); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vin  [3] = '{8'd0, 8'd1, 8'd99};
        logic [11:0] vexp [3] = '{12'h000, 12'h001, 12'h099};
        logic [11:0] r; logic ovf; int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_conv(3, vin[i], r, ovf, lat, bc);
            tests++; if (r !== vexp[i]) begin fails++; $display("FAIL b2b_bcd[%0d] got %h want %h", i, r, vexp[i]); end
            tests++; if (lat != 10) begin fails++; $display("FAIL b2b_spacing[%0d] got %0d want 10", i, lat); end
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [11:0] r; logic ovf; int lat, bc;
        run_conv(2, 8'd123, r, ovf, lat, bc);
        tests++; if (r !== 12'h023) begin fails++; $display("FAIL ovf123_bcd got %h want 023", r); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf123_flag got %b want 1", ovf); end
`ifdef BIN2BCD_SEG7_EN
        tests++; if (seg2 !== {7'b0111111, 7'b0111111}) begin fails++; $display("FAIL ovf123_seg got %b want 01111110111111", seg2); end
`endif
        tick();
        run_conv(2, 8'd45, r, ovf, lat, bc);
        tests++; if (r !== 12'h045) begin fails++; $display("FAIL ovf45_bcd got %h want 045", r); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf45_flag got %b want 0", ovf); end
        tick();
        run_conv(2, 8'd150, r, ovf, lat, bc);
        tests++; if (r !== 12'h050) begin fails++; $display("FAIL ovf150_bcd got %h want 050", r); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf150_flag got %b want 1", ovf); end
`ifdef BIN2BCD_SEG7_EN
        tests++; if (seg2 !== {7'b0111111, 7'b0111111}) begin fails++; $display("FAIL ovf150_seg got %b want 01111110111111", seg2); end
`endif
        tick();
    endtask

    task automatic test_ignore_start();
        bit seen; int lat, extra; logic [11:0] r;
        seen = 0; lat = -1; extra = 0; r = '0;
        start3 = 1'b1; bin3 = 8'd17;
        tick();
        start3 = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c == 3) begin start3 = 1'b1; bin3 = 8'd200; end
            if (c == 4) start3 = 1'b0;
            if (done3) begin seen = 1; lat = c; r = bcd3; end
            if (!seen) tick();
        end
        tests++; if (r !== 12'h017) begin fails++; $display("FAIL ignore_bcd got %h want 017", r); end
        tests++; if (lat != 10) begin fails++; $display("FAIL ignore_latency got %0d want 10", lat); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done3) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL ignore_no_second_done got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_abort();
        logic [11:0] r; logic ovf; int lat, bc, extra;
        extra = 0;
        start3 = 1'b1; bin3 = 8'd250;
        tick();
        start3 = 1'b0;
        tick(); tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy3); end
        tests++; if (done3 !== 1'b0) begin fails++; $display("FAIL abort_done got %b want 0", done3); end
        tests++; if (bcd3 !== 12'h000) begin fails++; $display("FAIL abort_bcd got %h want 000", bcd3); end
        tests++; if (ovf2 !== 1'b0) begin fails++; $display("FAIL abort_ovf2 got %b want 0", ovf2); end
        #1 reset_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done3 || busy3) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL abort_quiet got %0d active cycles want 0", extra); end
        run_conv(3, 8'd250, r, ovf, lat, bc);
        tests++; if (r !== 12'h250) begin fails++; $display("FAIL abort_rerun_bcd got %h want 250", r); end
        tests++; if (lat != 10) begin fails++; $display("FAIL abort_rerun_latency got %0d want 10", lat); end
        tick();
    endtask

`ifdef BIN2BCD_SEG7_EN
    task automatic test_seg7();
        logic [11:0] r; logic ovf; int lat, bc;
        run_conv(3, 8'd7, r, ovf, lat, bc);
        tests++; if (seg3 !== {7'b1111111, 7'b1111111, 7'b1111000}) begin fails++; $display("FAIL seg_7 got %b want 111111111111111111000", seg3); end
        tick();
        run_conv(3, 8'd105, r, ovf, lat, bc);
        tests++; if (seg3 !== {7'b1111001, 7'b1000000, 7'b0010010}) begin fails++; $display("FAIL seg_105 got %b want 111100110000000010010", seg3); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_max();
        test_back_to_back();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
`ifdef BIN2BCD_SEG7_EN
        test_seg7();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
